// File: rtl/argmax_arbiter_pkg.sv
// rtl/argmax_arbiter_pkg.sv - shared state encoding and engine defaults
package argmax_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LAUNCH = 2'd1,
    WAIT   = 2'd2,
    RESP   = 2'd3
  } state_t;

  // Engine instantiation must agree with these when left at defaults
  localparam int DEF_INPUT_NUM  = 10;
  localparam int DEF_DATA_WIDTH = 16;

endpackage

// File: rtl/argmax_arbiter_rr_pick.sv
// rtl/argmax_arbiter_rr_pick.sv - combinational round-robin priority picker
module argmax_arbiter_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id,
  output logic               any
);

  // rr_ptr is always < NUM_REQ, so one subtraction is enough to wrap
  function automatic int wrap_idx(input int base, input int off);
    int s;
    s = base + off;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s;
  endfunction

  int idx;

  always_comb begin
    grant    = '0;
    grant_id = '0;
    any      = 1'b0;
    idx      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = wrap_idx(int'(rr_ptr), i);
      if (!any && req[idx]) begin
        any        = 1'b1;
        grant_id   = ID_W'(idx);
        grant[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/argmax_arbiter.sv
// rtl/argmax_arbiter.sv - round-robin sharing of one argmax engine across lanes
module argmax_arbiter
  import argmax_arbiter_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int INPUT_NUM  = DEF_INPUT_NUM,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int TIMEOUT    = 64,
  parameter int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_REQ-1:0]                      req_valid,
  input  logic [NUM_REQ*INPUT_NUM*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]                      req_ready,
  output logic                                    rsp_valid,
  input  logic                                    rsp_ready,
  output logic [ID_W-1:0]                         rsp_id,
  output logic [DATA_WIDTH-1:0]                   rsp_class,
  output logic                                    rsp_timeout,
  output logic [INPUT_NUM*DATA_WIDTH-1:0]         mf_data_in,
  output logic                                    mf_data_valid,
  input  logic [DATA_WIDTH-1:0]                   mf_output_data,
  input  logic                                    mf_output_valid,
  output logic                                    busy
);

  localparam int VW = INPUT_NUM * DATA_WIDTH;
  localparam int TW = $clog2(TIMEOUT);

  state_t              state;
  logic [ID_W-1:0]     rr_ptr;
  logic [ID_W-1:0]     cur_id;
  logic [TW-1:0]       timer;
  logic [NUM_REQ-1:0]  grant;
  logic [ID_W-1:0]     grant_id;
  logic                any;
  logic [VW-1:0]       sel_vec;
  logic [ID_W-1:0]     next_ptr;

  argmax_arbiter_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req      (req_valid),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .grant_id (grant_id),
    .any      (any)
  );

  assign req_ready = (state == IDLE) ? grant : '0;
  assign next_ptr  = (cur_id == ID_W'(NUM_REQ - 1)) ? '0 : cur_id + 1'b1;

  always_comb begin
    sel_vec = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_vec = req_data[i*VW +: VW];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      rr_ptr        <= '0;
      cur_id        <= '0;
      timer         <= '0;
      mf_data_in    <= '0;
      mf_data_valid <= 1'b0;
      rsp_valid     <= 1'b0;
      rsp_id        <= '0;
      rsp_class     <= '0;
      rsp_timeout   <= 1'b0;
      busy          <= 1'b0;
    end else begin
      mf_data_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (any) begin
            mf_data_in    <= sel_vec;
            cur_id        <= grant_id;
            mf_data_valid <= 1'b1;
            busy          <= 1'b1;
            state         <= LAUNCH;
          end
        end
        LAUNCH: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          // A result landing on the expiry cycle still counts as a real answer
          if (mf_output_valid) begin
            rsp_class   <= mf_output_data;
            rsp_timeout <= 1'b0;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else if (timer == TW'(TIMEOUT - 1)) begin
            rsp_class   <= '0;
            rsp_timeout <= 1'b1;
            rsp_id      <= cur_id;
            rsp_valid   <= 1'b1;
            state       <= RESP;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            rr_ptr    <= next_ptr;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_argmax_arbiter.sv
// tb/tb_argmax_arbiter.sv - directed self-checking bench with a behavioural argmax engine
module tb_argmax_arbiter;

  localparam int NUM_REQ    = 4;
  localparam int INPUT_NUM  = 10;
  localparam int DATA_WIDTH = 16;
  localparam int TIMEOUT    = 64;
  localparam int ID_W       = 2;
  localparam int VW         = INPUT_NUM * DATA_WIDTH;

  logic                        clk = 1'b0;
  logic                        rst = 1'b1;
  logic [NUM_REQ-1:0]          req_valid = '0;
  logic [NUM_REQ*VW-1:0]       req_data = '0;
  logic [NUM_REQ-1:0]          req_ready;
  logic                        rsp_valid;
  logic                        rsp_ready = 1'b1;
  logic [ID_W-1:0]             rsp_id;
  logic [DATA_WIDTH-1:0]       rsp_class;
  logic                        rsp_timeout;
  logic [VW-1:0]               mf_data_in;
  logic                        mf_data_valid;
  logic [DATA_WIDTH-1:0]       mf_output_data = '0;
  logic                        mf_output_valid = 1'b0;
  logic                        busy;

  int checks = 0;
  int errors = 0;

  int cyc = 0;
  int mdv_cyc = 0;
  int mdv_count = 0;
  int rr_count [NUM_REQ];
  bit stall = 1'b0;
  bit stray = 1'b0;
  int eng_lat = INPUT_NUM;

  argmax_arbiter #(
    .NUM_REQ    (NUM_REQ),
    .INPUT_NUM  (INPUT_NUM),
    .DATA_WIDTH (DATA_WIDTH),
    .TIMEOUT    (TIMEOUT),
    .ID_W       (ID_W)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_data        (req_data),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_class       (rsp_class),
    .rsp_timeout     (rsp_timeout),
    .mf_data_in      (mf_data_in),
    .mf_data_valid   (mf_data_valid),
    .mf_output_data  (mf_output_data),
    .mf_output_valid (mf_output_valid),
    .busy            (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [VW-1:0] make_vec(input int idx, input logic [DATA_WIDTH-1:0] peak);
    logic [VW-1:0] v;
    for (int k = 0; k < INPUT_NUM; k++) v[k*DATA_WIDTH +: DATA_WIDTH] = 16'h0010;
    v[idx*DATA_WIDTH +: DATA_WIDTH] = peak;
    return v;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] argmax(input logic [VW-1:0] v);
    int best;
    best = 0;
    for (int k = 1; k < INPUT_NUM; k++)
      if (v[k*DATA_WIDTH +: DATA_WIDTH] > v[best*DATA_WIDTH +: DATA_WIDTH]) best = k;
    return DATA_WIDTH'(best);
  endfunction

  // Engine model plus pulse counters, all evaluated at the falling edge
  initial begin
    bit pending;
    int cnt;
    logic [DATA_WIDTH-1:0] res;
    pending = 1'b0;
    cnt = 0;
    res = '0;
    for (int i = 0; i < NUM_REQ; i++) rr_count[i] = 0;
    forever begin
      @(negedge clk);
      mf_output_valid = 1'b0;
      if (rst) begin
        pending = 1'b0;
      end else begin
        if (pending) begin
          if (cnt == 1) begin
            pending = 1'b0;
            if (!stall) begin
              mf_output_valid = 1'b1;
              mf_output_data  = res;
            end
          end else begin
            cnt = cnt - 1;
          end
        end
        if (stray) begin
          mf_output_valid = 1'b1;
          mf_output_data  = 16'h0003;
        end
        if (mf_data_valid) begin
          pending   = 1'b1;
          cnt       = eng_lat;
          res       = argmax(mf_data_in);
          mdv_cyc   = cyc;
          mdv_count = mdv_count + 1;
        end
      end
      for (int i = 0; i < NUM_REQ; i++) if (req_ready[i]) rr_count[i] = rr_count[i] + 1;
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    rsp_ready = 1'b1;
    stall     = 1'b0;
    stray     = 1'b0;
    eng_lat   = INPUT_NUM;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // which: 0 = mf_data_valid, 1 = rsp_valid, 2 = any req_ready
  task automatic wait_neg(input int which, input int budget, output bit ok);
    ok = 1'b0;
    for (int n = 0; n < budget; n++) begin
      @(negedge clk);
      if ((which == 0 && mf_data_valid) || (which == 1 && rsp_valid) ||
          (which == 2 && (|req_ready))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req_valid = 4'b1111;
    @(posedge clk);
    @(negedge clk);
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (mf_data_valid !== 1'b0) begin errors++; $display("FAIL reset_mf_data_valid got %b want 0", mf_data_valid); end
    checks++; if (mf_data_in !== '0) begin errors++; $display("FAIL reset_mf_data_in got %h want 0", mf_data_in); end
    checks++; if ({rsp_id, rsp_class, rsp_timeout} !== '0) begin errors++; $display("FAIL reset_rsp_fields got id %0d class %0d to %b want 0", rsp_id, rsp_class, rsp_timeout); end
    do_reset();
  endtask

  task automatic test_single();
    bit ok;
    int b_rr, b_mdv;
    do_reset();
    req_data[2*VW +: VW] = make_vec(7, 16'h0500);
    b_rr  = rr_count[2];
    b_mdv = mdv_count;
    req_valid = 4'b0100;
    wait_neg(2, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_grant_wait got none want grant"); end
    checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_req_ready got %b want 0100", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    wait_neg(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_rsp_wait got none want rsp_valid"); end
    checks++; if (cyc - mdv_cyc !== INPUT_NUM + 1) begin errors++; $display("FAIL single_latency got %0d want %0d", cyc - mdv_cyc, INPUT_NUM + 1); end
    checks++; if ({rsp_id, rsp_class, rsp_timeout} !== {2'd2, 16'd7, 1'b0}) begin errors++; $display("FAIL single_rsp got id %0d class %0d to %b want id 2 class 7 to 0", rsp_id, rsp_class, rsp_timeout); end
    @(posedge clk); #1;
    repeat (3) @(negedge clk);
    checks++; if (rr_count[2] - b_rr !== 1) begin errors++; $display("FAIL single_ready_pulses got %0d want 1", rr_count[2] - b_rr); end
    checks++; if (mdv_count - b_mdv !== 1) begin errors++; $display("FAIL single_launch_pulses got %0d want 1", mdv_count - b_mdv); end
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL single_idle got %b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_round_robin();
    bit ok;
    int exp_id [5] = '{0, 1, 2, 3, 0};
    int exp_cls [4] = '{3, 8, 0, 9};
    int last_rsp;
    do_reset();
    for (int i = 0; i < NUM_REQ; i++) req_data[i*VW +: VW] = make_vec(exp_cls[i], 16'h0100 + 16'(i));
    req_valid = 4'b1111;
    last_rsp = 0;
    for (int k = 0; k < 5; k++) begin
      wait_neg(1, 100, ok);
      checks++; if (!ok) begin errors++; $display("FAIL rr_rsp_wait_%0d got none want rsp_valid", k); end
      checks++; if (rsp_id !== ID_W'(exp_id[k])) begin errors++; $display("FAIL rr_order_%0d got %0d want %0d", k, rsp_id, exp_id[k]); end
      checks++; if (rsp_class !== DATA_WIDTH'(exp_cls[exp_id[k]])) begin errors++; $display("FAIL rr_class_%0d got %0d want %0d", k, rsp_class, exp_cls[exp_id[k]]); end
      if (k > 0) begin
        checks++; if (cyc - last_rsp > INPUT_NUM + 4) begin errors++; $display("FAIL rr_service_%0d got %0d want <= %0d", k, cyc - last_rsp, INPUT_NUM + 4); end
      end
      last_rsp = cyc;
      @(posedge clk); #1;
      if (k == 4) req_valid = '0;
    end
    repeat (3) @(negedge clk);
    checks++; if ({rsp_valid, busy} !== 2'b00) begin errors++; $display("FAIL rr_drain got %b want 00", {rsp_valid, busy}); end
  endtask

  task automatic test_backpressure();
    bit ok;
    do_reset();
    req_data[1*VW +: VW] = make_vec(5, 16'h0400);
    req_data[2*VW +: VW] = make_vec(2, 16'h0300);
    req_valid = 4'b0110;
    rsp_ready = 1'b0;
    wait_neg(2, 20, ok);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL bp_first_grant got %b want 0010", req_ready); end
    @(posedge clk); #1 req_valid[1] = 1'b0;
    wait_neg(1, 100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_rsp_wait got none want rsp_valid"); end
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({rsp_valid, rsp_id, rsp_class, rsp_timeout, req_ready} !== {1'b1, 2'd1, 16'd5, 1'b0, 4'b0000}) begin
        errors++;
        $display("FAIL bp_hold_%0d got v %b id %0d class %0d to %b rdy %b want v 1 id 1 class 5 to 0 rdy 0000",
                 i, rsp_valid, rsp_id, rsp_class, rsp_timeout, req_ready);
      end
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    checks++; if ({rsp_valid, req_ready} !== 5'b0_0100) begin errors++; $display("FAIL bp_next_grant got v %b rdy %b want v 0 rdy 0100", rsp_valid, req_ready); end
    @(posedge clk); #1 req_valid[2] = 1'b0;
    wait_neg(1, 100, ok);
    checks++; if ({ok, rsp_id, rsp_class} !== {1'b1, 2'd2, 16'd2}) begin errors++; $display("FAIL bp_second_rsp got ok %b id %0d class %0d want ok 1 id 2 class 2", ok, rsp_id, rsp_class); end
    @(posedge clk); #1;
  endtask

  task automatic test_timeout();
    bit ok;
    do_reset();
    stall = 1'b1;
    req_data[0 +: VW] = make_vec(4, 16'h0200);
    req_valid = 4'b0001;
    wait_neg(2, 20, ok);
    @(posedge clk); #1 req_valid = '0;
    wait_neg(1, 200, ok);
    checks++; if (!ok) begin errors++; $display("FAIL to_rsp_wait got none want rsp_valid"); end
    checks++; if (cyc - mdv_cyc !== TIMEOUT + 1) begin errors++; $display("FAIL to_latency got %0d want %0d", cyc - mdv_cyc, TIMEOUT + 1); end
    checks++; if ({rsp_id, rsp_class, rsp_timeout} !== {2'd0, 16'd0, 1'b1}) begin errors++; $display("FAIL to_rsp got id %0d class %0d to %b want id 0 class 0 to 1", rsp_id, rsp_class, rsp_timeout); end
    @(posedge clk); #1 stall = 1'b0;
    req_data[1*VW +: VW] = make_vec(6, 16'h0250);
    req_valid = 4'b0010;
    wait_neg(2, 20, ok);
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL to_next_grant got %b want 0010", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    wait_neg(1, 100, ok);
    checks++; if ({ok, rsp_id, rsp_class, rsp_timeout} !== {1'b1, 2'd1, 16'd6, 1'b0}) begin errors++; $display("FAIL to_next_rsp got ok %b id %0d class %0d to %b want ok 1 id 1 class 6 to 0", ok, rsp_id, rsp_class, rsp_timeout); end
    checks++; if (cyc - mdv_cyc !== INPUT_NUM + 1) begin errors++; $display("FAIL to_next_latency got %0d want %0d", cyc - mdv_cyc, INPUT_NUM + 1); end
    @(posedge clk); #1;
    // Result arriving in the very cycle the watchdog expires
    eng_lat = TIMEOUT;
    req_data[2*VW +: VW] = make_vec(9, 16'h0333);
    req_valid = 4'b0100;
    wait_neg(2, 20, ok);
    @(posedge clk); #1 req_valid = '0;
    wait_neg(1, 200, ok);
    checks++; if ({ok, rsp_id, rsp_class, rsp_timeout} !== {1'b1, 2'd2, 16'd9, 1'b0}) begin errors++; $display("FAIL edge_rsp got ok %b id %0d class %0d to %b want ok 1 id 2 class 9 to 0", ok, rsp_id, rsp_class, rsp_timeout); end
    checks++; if (cyc - mdv_cyc !== TIMEOUT + 1) begin errors++; $display("FAIL edge_latency got %0d want %0d", cyc - mdv_cyc, TIMEOUT + 1); end
    @(posedge clk); #1 eng_lat = INPUT_NUM;
  endtask

  task automatic test_reset_mid();
    bit ok;
    int b_mdv;
    do_reset();
    req_data[1*VW +: VW] = make_vec(1, 16'h0700);
    req_valid = 4'b0010;
    wait_neg(0, 20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL mid_launch_wait got none want mf_data_valid"); end
    repeat (3) @(negedge clk);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    b_mdv = mdv_count;
    @(negedge clk);
    checks++; if ({rsp_valid, busy, mf_data_valid, rsp_timeout} !== 4'b0000) begin errors++; $display("FAIL mid_flags got %b want 0000", {rsp_valid, busy, mf_data_valid, rsp_timeout}); end
    checks++; if ({mf_data_in, rsp_id, rsp_class} !== '0) begin errors++; $display("FAIL mid_regs got data %h id %0d class %0d want 0", mf_data_in, rsp_id, rsp_class); end
    checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL mid_regrant got %b want 0010", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    wait_neg(1, 100, ok);
    checks++; if ({ok, rsp_id, rsp_class, rsp_timeout} !== {1'b1, 2'd1, 16'd1, 1'b0}) begin errors++; $display("FAIL mid_rsp got ok %b id %0d class %0d to %b want ok 1 id 1 class 1 to 0", ok, rsp_id, rsp_class, rsp_timeout); end
    checks++; if (cyc - mdv_cyc !== INPUT_NUM + 1) begin errors++; $display("FAIL mid_latency got %0d want %0d", cyc - mdv_cyc, INPUT_NUM + 1); end
    checks++; if (mdv_count - b_mdv !== 1) begin errors++; $display("FAIL mid_launches got %0d want 1", mdv_count - b_mdv); end
    @(posedge clk); #1;
  endtask

  task automatic test_stray();
    bit ok;
    do_reset();
    repeat (2) @(negedge clk);
    @(posedge clk); #1 stray = 1'b1;
    @(posedge clk); #1 stray = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if ({rsp_valid, busy, mf_data_valid} !== 3'b000) begin errors++; $display("FAIL stray_idle_%0d got %b want 000", i, {rsp_valid, busy, mf_data_valid}); end
    end
    req_data[3*VW +: VW] = make_vec(0, 16'h0600);
    req_valid = 4'b1000;
    wait_neg(2, 20, ok);
    checks++; if (req_ready !== 4'b1000) begin errors++; $display("FAIL stray_grant got %b want 1000", req_ready); end
    @(posedge clk); #1 req_valid = '0;
    wait_neg(1, 100, ok);
    checks++; if ({ok, rsp_id, rsp_class, rsp_timeout} !== {1'b1, 2'd3, 16'd0, 1'b0}) begin errors++; $display("FAIL stray_rsp got ok %b id %0d class %0d to %b want ok 1 id 3 class 0 to 0", ok, rsp_id, rsp_class, rsp_timeout); end
    checks++; if (cyc - mdv_cyc !== INPUT_NUM + 1) begin errors++; $display("FAIL stray_latency got %0d want %0d", cyc - mdv_cyc, INPUT_NUM + 1); end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_timeout();
    test_reset_mid();
    test_stray();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/argmax_arbiter.md
Name: argmax_arbiter

Overview:
Shares one maxfinder argmax engine between NUM_REQ inference lanes. Each lane submits a packed output-layer score vector.
- Arbitration is round-robin.
- The block launches the engine with the granted lane's vector and waits for the winning class index.
- It returns the index, tagged with the lane ID, on a single response port with backpressure.
- A watchdog converts a missing engine result into a timeout response, so a lane is never hung.

Parameters:
NUM_REQ, 4, number of requesting lanes (2..16)
INPUT_NUM, 10, scores per vector; must match the engine's INPUT_NUM
DATA_WIDTH, 16, bits per score and per class index; must match the engine's DATA_WIDTH
TIMEOUT, 64, WAIT-state cycles before timeout; must be > INPUT_NUM+1
ID_W, $clog2(NUM_REQ) (minimum 1), width of the lane ID

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous reset, active-high
req_valid  in  NUM_REQ  per-lane request pending
req_data  in  NUM_REQ*INPUT_NUM*DATA_WIDTH  lane i vector at bits [i*INPUT_NUM*DATA_WIDTH +: INPUT_NUM*DATA_WIDTH]
req_ready  out  NUM_REQ  one-hot accept pulse
rsp_valid  out  1  response available
rsp_ready  in  1  consumer accepts response
rsp_id  out  ID_W  lane that owns the response
rsp_class  out  DATA_WIDTH  argmax index from the engine
rsp_timeout  out  1  engine did not answer; rsp_class=0
mf_data_in  out  INPUT_NUM*DATA_WIDTH  vector to engine
mf_data_valid  out  1  one-cycle engine start
mf_output_data  in  DATA_WIDTH  engine index result
mf_output_valid  in  1  engine result strobe
busy  out  1  high in every state except IDLE

Behaviour:
- Reset: state=IDLE, rr_ptr=0, timer=0.
- Reset values, all outputs: req_ready=0, rsp_valid=0, rsp_id=0, rsp_class=0, rsp_timeout=0, mf_data_in=0, mf_data_valid=0, busy=0.
- Reset mid-operation aborts immediately; no response is produced for the aborted request.
- IDLE:
  - If any req_valid is high, select the first set bit scanning rr_ptr, rr_ptr+1, ... modulo NUM_REQ.
  - Pulse req_ready for that lane for exactly this cycle.
  - Capture its vector into mf_data_in and its ID into cur_id, then go to LAUNCH.
  - req_ready is combinational from state, req_valid and rr_ptr; all other outputs are registered.
- LAUNCH: mf_data_valid=1 for exactly one cycle, timer<=0, go to WAIT.
- WAIT:
  - If mf_output_valid: rsp_class<=mf_output_data, rsp_timeout<=0, rsp_id<=cur_id, go to RESP.
  - Else if timer==TIMEOUT-1: rsp_class<=0, rsp_timeout<=1, rsp_id<=cur_id, go to RESP.
  - Else timer<=timer+1.
  - If mf_output_valid arrives in the same cycle as the timer expiry, it wins and no timeout is flagged.
- RESP:
  - rsp_valid=1, with rsp_id, rsp_class and rsp_timeout held stable until rsp_ready is sampled high.
  - On the handshake: rsp_valid<=0, rr_ptr<=(cur_id+1) mod NUM_REQ, go to IDLE.
- mf_data_in stays constant from capture until the next grant.
- mf_output_valid outside WAIT is ignored.
- req_valid deasserting while not granted is legal; the lane simply loses eligibility.
- A lane must hold req_data stable while req_valid is high.
- Nominal engine latency: mf_output_valid is seen INPUT_NUM cycles after mf_data_valid.
- Service time per request ≈ INPUT_NUM+4 cycles when rsp_ready is held high.
- A new request arriving in the same cycle as the RESP handshake waits one cycle (IDLE bubble).
- Fairness: a continuously requesting lane is served at least once every NUM_REQ grants.

Decomposition:
- Shared package: state encoding constants (IDLE=2'd0, LAUNCH=2'd1, WAIT=2'd2, RESP=2'd3) and default INPUT_NUM/DATA_WIDTH, so the arbiter and engine instantiations agree.
- One natural sub-module: rr_pick, a combinational round-robin priority picker.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, grant_id, any.
- The FSM, timer and response registers stay in the top module.
- The maxfinder instance lives outside, in the integration level, wired to the mf_* ports.
- The integration level drives the engine's active-low reset from ~rst.

Test Plan:
- Single request: lane 2 vector with score 0x0500 at index 7, all others 0x0010.
  -> req_ready[2] pulses once; mf_data_valid pulses once.
  -> rsp_valid with rsp_id=2, rsp_class=7, rsp_timeout=0, exactly INPUT_NUM+1 cycles after mf_data_valid.
- All four lanes requesting continuously after reset, rsp_ready=1.
  -> grant order 0,1,2,3,0; each rsp_class matches its lane's planted maximum.
- Backpressure: rsp_ready=0 for 20 cycles during RESP.
  -> rsp_valid/rsp_id/rsp_class stay stable; no new req_ready.
  -> after rsp_ready=1, the next grant follows one cycle after the handshake.
- Engine stalled (mf_output_valid forced 0), TIMEOUT=64.
  -> after 64 WAIT cycles, rsp_valid with rsp_timeout=1, rsp_class=0.
  -> the next lane is then served normally.
- rst asserted for one cycle while in WAIT with lane 1 granted.
  -> next cycle all outputs at reset values, no response for lane 1.
  -> a pending lane 1 request is then re-granted first (rr_ptr=0, lanes 0 idle).
- Stray mf_output_valid pulse in IDLE.
  -> ignored; no rsp_valid and no state change.
